hamming_tx_serializer: RTL and testbench
========================================

# hamming_tx_serializer

Accepts one data byte per transaction over a valid/ready handshake and encodes it as a Hamming(12,8) codeword. It optionally flips one codeword bit for fault injection, then transmits the word on a single serial line as a UART-style frame: start bit, 12 code bits, stop bit. It sits directly upstream of the 12-bit Hamming corrector, which consumes the same codeword layout at the receive end. The latched codeword is also exposed in parallel so benches can drive the corrector directly.

## Interface
Parameters:
- CLKS_PER_BIT, 4: clock cycles per serial bit; legal range 1..1023.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_data  input  8  byte to encode, D[7:0].
- in_valid  input  1  in_data/err_pos are valid.
- in_ready  output  1  block can accept a byte this cycle.
- err_pos  input  4  fault injection sampled with in_data; 0 = none, 1..12 = flip codeword position p (bit H[p-1]), 13..15 = none.
- tx_out  output  1  serial line; idle high.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.
- tx_code  output  12  codeword latched for the current or last frame, including any injected flip.

## Operation
Codeword layout (position p = H[p-1]):
- Parity bits: H[0], H[1], H[3], H[7].
- Data bits: D0..D7 → H[2], H[4], H[5], H[6], H[8], H[9], H[10], H[11].

Parity equations:
- H[0] = D0^D1^D3^D4^D6
- H[1] = D0^D2^D3^D5^D6
- H[3] = D1^D2^D3^D7
- H[7] = D4^D5^D6^D7

Handshake:
- Accept occurs when in_valid && in_ready.
- in_ready = 1 only in IDLE.
- in_data and err_pos must be stable only in the accept cycle.

FSM states and transitions:
- IDLE → START on accept. Encode, apply the err_pos flip, and latch the result into tx_code and the shift register.
- START → DATA after CLKS_PER_BIT cycles.
- DATA: shifts LSB-first (H[0] first, H[11] last); each bit is held CLKS_PER_BIT cycles. Bit index 0..11; → STOP after bit 11.
- STOP → IDLE after CLKS_PER_BIT cycles.

Line levels per state: IDLE = 1, START = 0, DATA = current bit, STOP = 1.

Counters:
- baud counter: width clog2(CLKS_PER_BIT)+1; counts 0..CLKS_PER_BIT-1, then wraps.
- bit index: 4 bits.

## Timing
- Reset values: tx_out=1, in_ready=1, busy=0, frame_done=0, tx_code=12'h000. The FSM and counters return to IDLE/0.
- Reset mid-frame aborts the frame. tx_out=1 on the cycle after rst is sampled; no frame_done is issued.
- The accept cycle is cycle 0. tx_out goes low in cycle 1.
- Code bit k occupies cycles 1+(k+1)·CLKS_PER_BIT .. (k+2)·CLKS_PER_BIT.
- The stop bit ends at cycle 14·CLKS_PER_BIT. frame_done is high in that cycle.
- in_ready=1 again in cycle 14·CLKS_PER_BIT+1, so back-to-back frames are separated by exactly 1 idle-high cycle.
- busy = 1 from cycle 1 through 14·CLKS_PER_BIT inclusive.
- tx_code is updated in cycle 1 and held until the next accept.
- in_valid while busy is ignored; no data is lost, because the source holds the byte until in_ready.
- CLKS_PER_BIT=1 is legal: 14-cycle frames.

## Structure
- Shared package hamming_pkg:
  - CODE_W=12, DATA_W=8.
  - Parity-position constants {0,1,3,7}.
  - Data-position constants {2,4,5,6,8,9,10,11}.
  - State typedef: IDLE, START, DATA, STOP.
- The corrector side also uses this package.
- One sub-module: hamming12_encode, purely combinational, D[7:0] → H[11:0]. It is instantiated here and reusable by the corrector bench as a reference model.
- Fault injection, the FSM, the baud counter and the shift register stay in the top module.

## Test plan
- Reset, then idle 20 cycles → tx_out=1, in_ready=1, busy=0, tx_code=12'h000.
- CLKS_PER_BIT=4; send in_data=8'hA5, err_pos=0 → tx_code=12'hA27; line samples at bit centres are 0, then 1,1,1,0,0,1,0,0,0,1,0,1, then 1; frame_done at cycle 56.
- in_data=8'hFF, err_pos=0 → tx_code=12'hF77. Then in_data=8'h00 → 12'h000, accepted exactly 57 cycles after the first accept.
- in_data=8'hA5, err_pos=6 → tx_code=12'hA07 (H[5] flipped). Feeding the corrector gives syndrome 6 and corrected byte 8'hA5. err_pos=14 → tx_code=12'hA27.
- Assert rst at cycle 20 of a frame → tx_out=1 and in_ready=1 next cycle, no frame_done. A new byte is then accepted and framed correctly.
- in_valid held high continuously with in_data changing while busy → only bytes presented in in_ready cycles are sent, each frame intact.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(12,8) definitions used by the serializer and the receive-side corrector.
package hamming_pkg;

    localparam int CODE_W = 12;
    localparam int DATA_W = 8;

    // Zero-based codeword indices; position p in the usual 1-based numbering is index p-1.
    localparam int PARITY_POS [4]      = '{0, 1, 3, 7};
    localparam int DATA_POS   [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

endpackage

// File: rtl/hamming12_encode.sv
// Combinational Hamming(12,8) encoder, D[7:0] -> H[11:0].
module hamming12_encode
    import hamming_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CODE_W-1:0] code_o
);

    // Scatter data bits into their slots, then fill in the four parity bits.
    always_comb begin
        code_o = '0;
        for (int i = 0; i < DATA_W; i++) begin
            code_o[DATA_POS[i]] = data_i[i];
        end
        code_o[PARITY_POS[0]] = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
        code_o[PARITY_POS[1]] = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
        code_o[PARITY_POS[2]] = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7];
        code_o[PARITY_POS[3]] = data_i[4] ^ data_i[5] ^ data_i[6] ^ data_i[7];
    end

endmodule

// File: rtl/hamming_tx_serializer.sv
// Encodes a byte as Hamming(12,8), optionally flips one bit, and sends it as a
// start + 12 code bits + stop frame on a single idle-high line.
module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        err_pos,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done,
    output logic [CODE_W-1:0] tx_code
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        BIT_LAST  = 4'(CODE_W - 1);

    state_e              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [3:0]          bit_q, bit_d;
    logic [CODE_W-1:0]   shift_q, shift_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                tx_out_q, tx_out_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                done_q, done_d;

    logic [CODE_W-1:0]   enc_s;
    logic [CODE_W-1:0]   flip_s;
    logic                baud_last_s;

    hamming12_encode u_enc (
        .data_i (in_data),
        .code_o (enc_s)
    );

    assign baud_last_s = (baud_q == BAUD_LAST);

    // Positions 1..12 select a single bit to invert; 0 and 13..15 inject nothing.
    always_comb begin
        if ((err_pos != 4'd0) && (err_pos <= 4'd12)) begin
            flip_s = {{(CODE_W-1){1'b0}}, 1'b1} << (err_pos - 4'd1);
        end else begin
            flip_s = '0;
        end
    end

    // Next state; outputs are derived from the next state so they land registered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        code_d  = code_q;

        case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = 4'd0;
                    code_d  = enc_s ^ flip_s;
                    shift_d = enc_s ^ flip_s;
                end else begin
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_last_s) begin
                    state_d = DATA;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (!baud_last_s) begin
                    baud_d = baud_q + BAUD_W'(1);
                end else if (bit_q == BIT_LAST) begin
                    state_d = STOP;
                    baud_d  = '0;
                end else begin
                    baud_d  = '0;
                    bit_d   = bit_q + 4'd1;
                    shift_d = shift_q >> 1;
                end
            end
            STOP: begin
                if (baud_last_s) begin
                    state_d = IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d  = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                bit_d   = 4'd0;
            end
        endcase

        case (state_d)
            IDLE:    tx_out_d = 1'b1;
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
            STOP:    tx_out_d = 1'b1;
            default: tx_out_d = 1'b1;
        endcase

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE);
        done_d  = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            code_q   <= '0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            code_q   <= code_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign tx_out     = tx_out_q;
    assign busy       = busy_q;
    assign in_ready   = ready_q;
    assign frame_done = done_q;
    assign tx_code    = code_q;

endmodule

// File: tb/tb_hamming_tx_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed codewords, a monitor decodes the serial line.
module tb_hamming_tx_serializer;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  err_pos;
    logic        tx_out;
    logic        busy;
    logic        frame_done;
    logic [11:0] tx_code;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [11:0] sb_q [$];
    bit          mon_active = 1'b0;

    hamming_tx_serializer #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .err_pos    (err_pos),
        .tx_out     (tx_out),
        .busy       (busy),
        .frame_done (frame_done),
        .tx_code    (tx_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] syndrome(input logic [11:0] h);
        logic [3:0] s;
        s[0] = h[0] ^ h[2] ^ h[4] ^ h[6] ^ h[8] ^ h[10];
        s[1] = h[1] ^ h[2] ^ h[5] ^ h[6] ^ h[9] ^ h[10];
        s[2] = h[3] ^ h[4] ^ h[5] ^ h[6] ^ h[11];
        s[3] = h[7] ^ h[8] ^ h[9] ^ h[10] ^ h[11];
        return s;
    endfunction

    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] d, input logic [3:0] e, input logic [11:0] exp,
                        output int acc_cyc);
        int n;
        in_data  = d;
        err_pos  = e;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            acc_cyc  = -1;
        end else begin
            sb_q.push_back(exp);
            acc_cyc = cyc;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((mon_active || sb_q.size() != 0 || !in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'd0, mon_active || sb_q.size() != 0 || !in_ready}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: a low line while idle marks cycle 1 of a frame; decode and compare.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx_out === 1'b0 && !mon_active) begin
                logic [11:0] exp_c;
                logic [11:0] got_c;
                bit          aborted;
                int          fd_cnt;
                mon_active = 1'b1;
                aborted    = 1'b0;
                fd_cnt     = 0;
                got_c      = '0;
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_frame", 32'd1, 32'd0);
                    exp_c = '0;
                end else begin
                    exp_c = sb_q.pop_front();
                end
                check("busy_cycle1", {31'd0, busy}, 32'd1);
                check("tx_code_cycle1", {20'd0, tx_code}, {20'd0, exp_c});
                for (int t = 1; t <= 14 * C; t++) begin
                    int ph;
                    int slot;
                    if (t > 1) @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    ph   = (t - 1) % C;
                    slot = (t - 1) / C;
                    if (frame_done) begin
                        fd_cnt++;
                        if (t != 14 * C) check("frame_done_early", t, 14 * C);
                    end
                    if (ph == C / 2) begin
                        if (slot == 0) check("start_bit", {31'd0, tx_out}, 32'd0);
                        else if (slot == 13) check("stop_bit", {31'd0, tx_out}, 32'd1);
                        else got_c[slot - 1] = tx_out;
                    end
                end
                if (!aborted) begin
                    check("serial_code", {20'd0, got_c}, {20'd0, exp_c});
                    check("frame_done_count", fd_cnt, 32'd1);
                    check("frame_done_last", {31'd0, frame_done}, 32'd1);
                    check("tx_code_held", {20'd0, tx_code}, {20'd0, exp_c});
                end
                mon_active = 1'b0;
            end
        end
    end

    initial begin : stim
        int a0, a1, a2;
        int fd_seen;
        logic [7:0] want [3];
        want[0] = 8'h01;
        want[1] = 8'h80;
        want[2] = 8'h3C;

        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        err_pos  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_tx_code", {20'd0, tx_code}, 32'd0);
        @(posedge clk);
        #1;

        send(8'hA5, 4'd0, 12'hA27, a0);
        wait_idle();

        send(8'hFF, 4'd0, 12'hF77, a1);
        send(8'h00, 4'd0, 12'h000, a2);
        check("back_to_back_gap", a2 - a1, 32'd57);
        wait_idle();

        send(8'hA5, 4'd6, 12'hA07, a0);
        wait_idle();
        check("syndrome_err6", {28'd0, syndrome(tx_code)}, 32'd6);
        send(8'hA5, 4'd14, 12'hA27, a0);
        wait_idle();
        check("syndrome_err14", {28'd0, syndrome(tx_code)}, 32'd0);

        // Abort a frame with reset in its cycle 20.
        send(8'hA5, 4'd0, 12'hA27, a0);
        while (cyc < a0 + 20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_tx_out", {31'd0, tx_out}, 32'd1);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        fd_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (frame_done) fd_seen++;
            @(negedge clk);
        end
        check("abort_no_frame_done", fd_seen, 32'd0);
        @(posedge clk);
        #1;
        send(8'h3C, 4'd0, 12'h362, a0);
        wait_idle();

        // in_valid held high; junk data while busy must never be framed.
        in_valid = 1'b1;
        for (int idx = 0; idx < 3; idx++) begin
            int n;
            n = 0;
            while (n < 300) begin
                in_data = 8'($urandom);
                err_pos = 4'($urandom);
                @(negedge clk);
                if (in_ready) begin
                    in_data = want[idx];
                    err_pos = 4'd0;
                    case (idx)
                        0:       sb_q.push_back(12'h007);
                        1:       sb_q.push_back(12'h888);
                        default: sb_q.push_back(12'h362);
                    endcase
                    @(posedge clk);
                    #1;
                    break;
                end
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 300) check("held_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        wait_idle();
        check("sb_drained", sb_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
